// File: rtl/decode_pkg.sv
// Shared opcode encodings and instruction field positions for the decode stage.
package decode_pkg;
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int LINK_BIT = 24;
    localparam int L_BIT    = 20;
    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;
    localparam int RM_HI    = 3;
    localparam int RM_LO    = 0;
endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue: storage array, wrapping pointers and occupancy count.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o
);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Guards keep the count bounded even if a caller misbehaves.
    assign do_push = push_i & ~clear_i & (cnt_q != FULL_C);
    assign do_pop  = pop_i  & ~clear_i & (cnt_q != '0);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue feeding the ID register, with bypass, stall, flush
// and register-address extraction from the ID register.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int PW    = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [PW-1:0] in_pc8,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [PW-1:0] out_pc8,
    output logic [3:0]    out_rd,
    output logic [3:0]    out_cond,
    output logic [3:0]    out_ra1,
    output logic [3:0]    out_ra2,
    output logic          out_bl,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [IW+PW-1:0] head;
    logic             push, advance, q_empty, pop, bypass, fifo_push;

    logic          vld_q, vld_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [PW-1:0] pc8_q, pc8_d;
    logic [1:0]    op;

    // Readiness looks at occupancy only, so a full queue refuses even when popping.
    assign in_ready  = (count < FULL_C);
    assign push      = in_valid & in_ready & ~flush;
    assign advance   = ~stall | flush;
    assign q_empty   = (count == '0);
    assign pop       = advance & ~flush & ~q_empty;
    assign bypass    = advance & ~flush & q_empty & push;
    assign fifo_push = push & ~bypass;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (IW + PW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (fifo_push),
        .pop_i   (pop),
        .clear_i (flush),
        .wdata_i ({in_instr, in_pc8}),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        vld_d   = vld_q;
        instr_d = instr_q;
        pc8_d   = pc8_q;
        if (flush || (advance && !pop && !bypass)) begin
            vld_d   = 1'b0;
            instr_d = '0;
            pc8_d   = '0;
        end else if (pop) begin
            vld_d   = 1'b1;
            instr_d = head[IW+PW-1:PW];
            pc8_d   = head[PW-1:0];
        end else if (bypass) begin
            vld_d   = 1'b1;
            instr_d = in_instr;
            pc8_d   = in_pc8;
        end
    end

    // ID register; bubbles are zeroed so they decode as harmless DP with r0 operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= 1'b0;
            instr_q <= '0;
            pc8_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            instr_q <= instr_d;
            pc8_q   <= pc8_d;
        end
    end

    assign op        = instr_q[OP_HI:OP_LO];
    assign out_valid = vld_q;
    assign out_instr = instr_q;
    assign out_pc8   = pc8_q;
    assign out_rd    = instr_q[RD_HI:RD_LO];
    assign out_cond  = instr_q[COND_HI:COND_LO];
    assign out_ra1   = (op == OP_BR) ? PC_REG : instr_q[RN_HI:RN_LO];
    assign out_ra2   = (op == OP_MEM && !instr_q[L_BIT]) ? instr_q[RD_HI:RD_LO]
                                                         : instr_q[RM_HI:RM_LO];
    assign out_bl    = (op == OP_BR) & instr_q[LINK_BIT];
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vectors from a table, plus queue/stall/flush/reset sequences
// checked against an ordering scoreboard and a small occupancy model.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, stall, flush;
    logic [31:0]   in_instr, in_pc8;
    logic          out_valid, out_bl;
    logic [31:0]   out_instr, out_pc8;
    logic [3:0]    out_rd, out_cond, out_ra1, out_ra2;
    logic [CW-1:0] count;

    decode_queue #(.DEPTH(DEPTH), .IW(32), .PW(32)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc8    (in_pc8),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc8   (out_pc8),
        .out_rd    (out_rd),
        .out_cond  (out_cond),
        .out_ra1   (out_ra1),
        .out_ra2   (out_ra2),
        .out_bl    (out_bl),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
    } item_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
        logic [3:0]  rd;
        logic [3:0]  cond;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        bl;
    } vec_t;

    item_t sb[$];
    item_t cur;
    int    mcnt;
    logic  mvalid;
    int    ncmp  = 0;
    int    nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mcnt   = 0;
        mvalid = 1'b0;
        cur    = '0;
        sb.delete();
    endtask

    // One clock: drive, predict, clock, compare.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl);
        logic acc, adv, load;
        int   ncnt;
        logic nvalid;
        in_valid = v; in_instr = ins; in_pc8 = pc; stall = st; flush = fl;
        acc  = v && (mcnt < DEPTH) && !fl;
        adv  = !st || fl;
        load = 1'b0;
        if (acc) sb.push_back('{instr: ins, pc8: pc});
        if (fl) begin
            ncnt = 0; nvalid = 1'b0; sb.delete();
        end else if (adv) begin
            load   = (mcnt > 0) || acc;
            ncnt   = (mcnt > 0) ? mcnt + int'(acc) - 1 : 0;
            nvalid = load;
        end else begin
            ncnt   = mcnt + int'(acc);
            nvalid = mvalid;
        end
        @(posedge clk);
        #1;
        mcnt   = ncnt;
        mvalid = nvalid;
        if (load) begin
            if (sb.size() == 0) begin
                nfail++; ncmp++;
                $display("FAIL scoreboard_underflow: actual=load required=empty");
                cur = '0;
            end else begin
                cur = sb.pop_front();
            end
        end else if (!mvalid) begin
            cur = '0;
        end
        chk("out_valid", 64'(out_valid), 64'(mvalid));
        chk("count", 64'(count), 64'(mcnt));
        chk("in_ready", 64'(in_ready), 64'(mcnt < DEPTH));
        chk("out_instr", 64'(out_instr), 64'(cur.instr));
        chk("out_pc8", 64'(out_pc8), 64'(cur.pc8));
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{32'hE0821003, 32'h108, 4'd1, 4'hE, 4'd2,  4'd3,  1'b0};
        tbl[1] = '{32'hEB000004, 32'h20C, 4'd0, 4'hE, 4'd15, 4'd4,  1'b1};
        tbl[2] = '{32'hE5812000, 32'h310, 4'd2, 4'hE, 4'd1,  4'd2,  1'b0};
        tbl[3] = '{32'hE5912000, 32'h414, 4'd2, 4'hE, 4'd1,  4'd0,  1'b0};
        tbl[4] = '{32'hEA000010, 32'h518, 4'd0, 4'hE, 4'd15, 4'd0,  1'b0};
        tbl[5] = '{32'h0123F45A, 32'h61C, 4'hF, 4'h0, 4'd3,  4'hA,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc8 = '0; stall = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back bypass pushes, each decoded the cycle after it is presented
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].instr, tbl[i].pc8, 1'b0, 1'b0);
            chk($sformatf("rd[%0d]", i),   64'(out_rd),   64'(tbl[i].rd));
            chk($sformatf("cond[%0d]", i), 64'(out_cond), 64'(tbl[i].cond));
            chk($sformatf("ra1[%0d]", i),  64'(out_ra1),  64'(tbl[i].ra1));
            chk($sformatf("ra2[%0d]", i),  64'(out_ra2),  64'(tbl[i].ra2));
            chk($sformatf("bl[%0d]", i),   64'(out_bl),   64'(tbl[i].bl));
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("bubble_ra1", 64'(out_ra1), 64'd0);
        chk("bubble_bl", 64'(out_bl), 64'd0);

        // Stall fill to full; fifth push refused, also refused with stall released while full
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA000_0000 + i, 32'h1000 + 4 * i, 1'b1, 1'b0);
        step(1'b1, 32'hA000_00FF, 32'h1FFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0);

        // Steady push/pop at count 2 across several pointer wraps
        for (int i = 0; i < 2; i++) step(1'b1, 32'hB000_0000 + i, 32'h2000 + i, 1'b1, 1'b0);
        for (int i = 2; i < 14; i++) step(1'b1, 32'hB000_0000 + i, 32'h2000 + i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);

        // Flush beats stall and drops the same-cycle push; next push bypasses
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + i, 32'h3000 + i, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD_0001, 32'hDEAD, 1'b1, 1'b1);
        step(1'b1, 32'hC000_00AA, 32'h30AA, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // Asynchronous reset between edges with a valid ID register and three queued
        step(1'b1, 32'hE000_0000, 32'h4000, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) step(1'b1, 32'hE000_0000 + i, 32'h4000 + i, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        chk("arst_out_pc8", 64'(out_pc8), 64'd0);
        model_reset();
        in_valid = 1'b0; stall = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 32'hE0821003, 32'h108, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
